// File: rtl/lshl_arbiter.sv
// Round-robin sequencer sharing one multi-cycle L_shl unit among NREQ client FSMs.
// Define LSHL_ARB_TIMEOUT_EN to add a watchdog that aborts a stalled L_shl service.

module lshl_arb_slot (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] a,
  input  logic [15:0] b,
  input  logic        done,
  output logic        pending,
  output logic [31:0] cap_a,
  output logic [15:0] cap_b
);
  logic accept;

  // a pulse coincident with this client's own completion re-arms the slot
  assign accept = req && (!pending || done);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
      cap_a   <= '0;
      cap_b   <= '0;
    end else if (accept) begin
      pending <= 1'b1;
      cap_a   <= a;
      cap_b   <= b;
    end else if (done) begin
      pending <= 1'b0;
    end
  end
endmodule

module lshl_arbiter #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0][31:0] req_a,
  input  logic [NREQ-1:0][15:0] req_b,
  output logic [NREQ-1:0]       req_done,
  output logic [31:0]           req_result,
  output logic                  L_shl_ready,
  output logic [31:0]           L_shl_a,
  output logic [15:0]           L_shl_b,
  input  logic [31:0]           L_shl_in,
  input  logic                  L_shl_done,
  output logic                  busy,
  output logic                  shl_timeout
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                state;
  logic [IW-1:0]         grant, rr_ptr, next_grant;
  logic [NREQ-1:0]       pending;
  logic [NREQ-1:0][31:0] cap_a;
  logic [NREQ-1:0][15:0] cap_b;
  logic                  in_svc, complete, abort;

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("lshl_arbiter: NREQ must be 2..8");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_tmo
    $error("lshl_arbiter: TIMEOUT_CYC must fit the 8-bit watchdog");
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    lshl_arb_slot u_slot (
      .clk     (clk),
      .reset   (reset),
      .req     (req_ready[i]),
      .a       (req_a[i]),
      .b       (req_b[i]),
      .done    (req_done[i]),
      .pending (pending[i]),
      .cap_a   (cap_a[i]),
      .cap_b   (cap_b[i])
    );
  end

  // nearest pending client after rr_ptr wins; scan far-to-near so the nearest overwrites
  always_comb begin
    next_grant = rr_ptr;
    for (int k = NREQ; k >= 1; k--) begin
      if (pending[IW'((int'(rr_ptr) + k) % NREQ)])
        next_grant = IW'((int'(rr_ptr) + k) % NREQ);
    end
  end

`ifdef LSHL_ARB_TIMEOUT_EN
  logic [7:0] wd_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               wd_cnt <= '0;
    else if (state == ISSUE)  wd_cnt <= '0;
    else if (state == WAIT)   wd_cnt <= wd_cnt + 8'd1;
  end

  assign abort = (state == WAIT) && !L_shl_done && (wd_cnt == 8'(TIMEOUT_CYC));
`else
  assign abort = 1'b0;
`endif

  assign in_svc      = (state == ISSUE) || (state == WAIT);
  assign complete    = in_svc && (L_shl_done || abort);
  assign req_result  = (in_svc && L_shl_done) ? L_shl_in : 32'h0;
  assign shl_timeout = abort;
  assign busy        = (|pending) || (state != IDLE);

  always_comb begin
    req_done = '0;
    if (complete) req_done[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      grant       <= '0;
      rr_ptr      <= IW'(NREQ - 1);
      L_shl_ready <= 1'b0;
      L_shl_a     <= '0;
      L_shl_b     <= '0;
    end else begin
      case (state)
        IDLE: if (|pending) begin
          grant       <= next_grant;
          L_shl_ready <= 1'b1;
          L_shl_a     <= cap_a[next_grant];
          L_shl_b     <= cap_b[next_grant];
          state       <= ISSUE;
        end
        ISSUE, WAIT: begin
          L_shl_ready <= 1'b0;
          if (complete) begin
            rr_ptr <= grant;
            state  <= IDLE;
          end else begin
            state  <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lshl_arbiter.sv
// Scoreboard bench for lshl_arbiter: directed scenarios plus randomized traffic against
// a queue-based round-robin model; a behavioural L_shl unit answers each issue.
module tb_lshl_arbiter;
  localparam int NREQ = 4;
  localparam int TMO  = 64;

  logic                  clk = 1'b0, reset = 1'b0;
  logic [NREQ-1:0]       req_ready = '0;
  logic [NREQ-1:0][31:0] req_a = '0;
  logic [NREQ-1:0][15:0] req_b = '0;
  logic [NREQ-1:0]       req_done;
  logic [31:0]           req_result, L_shl_a, L_shl_in;
  logic [15:0]           L_shl_b;
  logic                  L_shl_ready, L_shl_done, busy, shl_timeout;

  logic        env_done = 1'b0, inject_done = 1'b0;
  logic [31:0] env_in = '0, inject_in = '0;
  assign L_shl_done = env_done | inject_done;
  assign L_shl_in   = env_done ? env_in : inject_in;

  always #5 clk = ~clk;

  lshl_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_done(req_done), .req_result(req_result), .L_shl_ready(L_shl_ready),
    .L_shl_a(L_shl_a), .L_shl_b(L_shl_b), .L_shl_in(L_shl_in), .L_shl_done(L_shl_done),
    .busy(busy), .shl_timeout(shl_timeout)
  );

  int tests = 0, fails = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_shl(logic [31:0] a, logic [15:0] b);
    return (b < 16'd32) ? (a << b[4:0]) : 32'h0;
  endfunction

  // behavioural L_shl: done env_lat cycles after the strobe (0 = never answers)
  int          env_rem = 0, env_lat = 4;
  bit          env_rand = 0;
  logic [31:0] env_res = '0;
  always @(negedge clk) if (reset && L_shl_ready) begin
    env_rem = env_rand ? int'($urandom_range(1, 5)) : env_lat;
    env_res = ref_shl(L_shl_a, L_shl_b);
  end
  always @(posedge clk) begin
    #1;
    env_done = 1'b0;
    env_in   = '0;
    if (!reset) env_rem = 0;
    else if (env_rem > 0) begin
      env_rem--;
      if (env_rem == 0) begin env_done = 1'b1; env_in = env_res; end
    end
  end

  // reference model: set of outstanding requests, served round-robin
  typedef struct {int cl; logic [31:0] res; bit tmo;} exp_t;
  exp_t        exp_q[$];
  exp_t        m_e;
  int          grant_log[$];
  logic [31:0] issue_a_log[$];
  bit          outst[NREQ];
  logic [31:0] oa[NREQ];
  logic [15:0] ob[NREQ];
  int          acc[NREQ], waited[NREQ];
  int          last = NREQ - 1, svc = -1, issue_cyc = 0, cyc = 0, max_wait = 0, m_w;
  bit          m_fin;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      for (int i = 0; i < NREQ; i++) begin outst[i] = 0; waited[i] = 0; end
      last = NREQ - 1;
      svc  = -1;
      exp_q.delete();
    end else begin
      m_fin = 0;
      if (svc >= 0 && L_shl_done) m_fin = 1;
`ifdef LSHL_ARB_TIMEOUT_EN
      else if (svc >= 0 && cyc - issue_cyc == TMO + 1) begin
        m_fin = 1;
        if (exp_q.size() > 0) begin exp_q[0].res = 32'h0; exp_q[0].tmo = 1; end
      end
`endif
      for (int i = 0; i < NREQ; i++)
        if (req_ready[i] && (!outst[i] || (m_fin && svc == i))) begin
          outst[i] = 1; oa[i] = req_a[i]; ob[i] = req_b[i]; acc[i] = cyc; waited[i] = 0;
        end
      if (m_fin) begin
        if (acc[svc] != cyc) outst[svc] = 0;
        last = svc;
        svc  = -1;
      end
      if (L_shl_ready) begin
        m_w = -1;
        for (int k = 1; k <= NREQ; k++)
          if (m_w < 0 && outst[(last + k) % NREQ] && acc[(last + k) % NREQ] <= cyc - 2)
            m_w = (last + k) % NREQ;
        if (svc >= 0 || m_w < 0) begin
          tests++; fails++;
          $display("FAIL issue_unexpected: L_shl_ready=1 a=%h, required no issue (svc=%0d)", L_shl_a, svc);
        end else begin
          chk("issue_a", L_shl_a, oa[m_w]);
          chk("issue_b", {16'h0, L_shl_b}, {16'h0, ob[m_w]});
          for (int j = 0; j < NREQ; j++)
            if (j != m_w && outst[j] && acc[j] <= cyc - 2) begin
              waited[j]++;
              if (waited[j] > max_wait) max_wait = waited[j];
            end
          waited[m_w] = 0;
          svc = m_w; issue_cyc = cyc;
          grant_log.push_back(m_w);
          issue_a_log.push_back(L_shl_a);
          exp_q.push_back('{m_w, ref_shl(oa[m_w], ob[m_w]), 1'b0});
        end
      end
    end
  end

  // monitor: pops the scoreboard whenever the DUT presents a completion
  always @(negedge clk) begin
    #1;
    if (reset) begin
      if (req_done != '0) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL done_unexpected: req_done=%b result=%h, required none", req_done, req_result);
        end else begin
          m_e = exp_q.pop_front();
          chk("done_onehot", {28'h0, req_done}, 32'(1) << m_e.cl);
          chk("done_result", req_result, m_e.res);
          chk("done_timeout", {31'h0, shl_timeout}, {31'h0, m_e.tmo});
        end
      end else begin
        chk("idle_result", req_result, 32'h0);
        chk("idle_timeout", {31'h0, shl_timeout}, 32'h0);
      end
    end
  end

  task automatic wait_ready(string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!L_shl_ready && n < 50);
    if (!L_shl_ready) begin
      tests++; fails++;
      $display("FAIL %s: L_shl_ready=0 after 50 cycles, required 1", name);
    end
  endtask

  task automatic wait_idle(string name, int bound);
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy || exp_q.size() != 0) && n < bound);
    chk(name, 32'(busy) + 32'(exp_q.size()), 32'h0);
  endtask

  task automatic chk_zero_outputs(string tag);
    chk({tag, "_L_shl_ready"}, {31'h0, L_shl_ready}, 32'h0);
    chk({tag, "_L_shl_a"}, L_shl_a, 32'h0);
    chk({tag, "_L_shl_b"}, {16'h0, L_shl_b}, 32'h0);
    chk({tag, "_req_done"}, {28'h0, req_done}, 32'h0);
    chk({tag, "_req_result"}, req_result, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_shl_timeout"}, {31'h0, shl_timeout}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required $finish");
    $fatal(1);
  end

  initial begin
    int nd, n;
    repeat (3) @(negedge clk);
    chk_zero_outputs("rst");
    @(posedge clk); #1 reset = 1'b1;

    // contention straight out of reset: service order 0, 2, 3
    grant_log.delete(); issue_a_log.delete(); env_lat = 3;
    @(posedge clk); #1;
    req_ready = 4'b1101;
    req_a[0] = 32'hA0A0_0001; req_b[0] = 16'd1;
    req_a[2] = 32'h0000_2222; req_b[2] = 16'd4;
    req_a[3] = 32'h3000_0003; req_b[3] = 16'd0;
    @(posedge clk); #1 req_ready = '0;
    nd = 0; n = 0;
    while (nd < 3 && n < 100) begin @(negedge clk); n++; if (req_done != '0) nd++; end
    chk("cont_done_count", nd, 3);
    chk("cont_busy_at_last_done", {31'h0, busy}, 32'h1);
    @(negedge clk);
    chk("cont_busy_after", {31'h0, busy}, 32'h0);
    chk("cont_len", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      chk("cont_g0", grant_log[0], 0); chk("cont_g1", grant_log[1], 2); chk("cont_g2", grant_log[2], 3);
      chk("cont_a0", issue_a_log[0], 32'hA0A0_0001);
      chk("cont_a1", issue_a_log[1], 32'h0000_2222);
      chk("cont_a2", issue_a_log[2], 32'h3000_0003);
    end

    // single request: strobe two cycles after the pulse, done four cycles later
    env_lat = 4;
    @(posedge clk); #1;
    req_ready[1] = 1'b1; req_a[1] = 32'h0001_2345; req_b[1] = 16'd3;
    @(negedge clk); chk("lat_t0", {31'h0, L_shl_ready}, 32'h0);
    @(posedge clk); #1 req_ready = '0;
    @(negedge clk); chk("lat_t1", {31'h0, L_shl_ready}, 32'h0);
    @(negedge clk); chk("lat_t2", {31'h0, L_shl_ready}, 32'h1);
    chk("lat_a", L_shl_a, 32'h0001_2345);
    chk("lat_b", {16'h0, L_shl_b}, 32'h3);
    nd = 0;
    repeat (3) begin @(negedge clk); if (req_done != '0) nd++; end
    chk("single_early_done", nd, 0);
    @(negedge clk);
    chk("single_done", {28'h0, req_done}, 32'h2);
    chk("single_result", req_result, 32'h0009_1A28);
    wait_idle("single_idle", 20);

    // round robin: clients 0 and 1 re-request on each completion
    grant_log.delete(); env_lat = 2;
    @(posedge clk); #1;
    req_ready = 4'b0011; req_a[0] = 32'h10; req_b[0] = 16'd1; req_a[1] = 32'h20; req_b[1] = 16'd2;
    @(posedge clk); #1 req_ready = '0;
    for (int it = 0; it < 8; it++) begin
      wait_ready("rr_issue");
      repeat (2) @(posedge clk); #1;
      req_ready = 4'b0011;
      req_a[0] = 32'h100 + 32'(it); req_a[1] = 32'h200 + 32'(it);
      @(posedge clk); #1 req_ready = '0;
    end
    wait_idle("rr_idle", 100);
    chk("rr_len_ge8", 32'(grant_log.size() >= 8), 32'h1);
    for (int k = 0; k < 8 && k < grant_log.size(); k++) chk("rr_alternate", grant_log[k], k % 2);

    // duplicate while queued / in service ignored; pulse at own completion accepted
    grant_log.delete(); issue_a_log.delete(); env_lat = 6;
    @(posedge clk); #1;
    req_ready[2] = 1'b1; req_a[2] = 32'h1111_0001; req_b[2] = 16'd1;
    @(posedge clk); #1;
    req_a[2] = 32'h2222_0002; req_b[2] = 16'd2;
    @(posedge clk); #1 req_ready = '0;
    wait_ready("dup_issue1");
    @(posedge clk); #1;
    req_ready[2] = 1'b1; req_a[2] = 32'h3333_0003; req_b[2] = 16'd3;
    @(posedge clk); #1 req_ready = '0;
    repeat (4) @(posedge clk); #1;
    req_ready[2] = 1'b1; req_a[2] = 32'h4444_0004; req_b[2] = 16'd4;
    @(posedge clk); #1 req_ready = '0;
    wait_idle("dup_idle", 50);
    chk("dup_len", issue_a_log.size(), 2);
    if (issue_a_log.size() == 2) begin
      chk("dup_a_first", issue_a_log[0], 32'h1111_0001);
      chk("dup_a_b2b", issue_a_log[1], 32'h4444_0004);
      chk("dup_g_b2b", grant_log[1], 2);
    end

    // stray L_shl_done while idle
    @(posedge clk); #1; inject_done = 1'b1; inject_in = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("stray_done", {28'h0, req_done}, 32'h0);
    chk("stray_result", req_result, 32'h0);
    chk("stray_busy", {31'h0, busy}, 32'h0);
    @(posedge clk); #1 inject_done = 1'b0;

    // asynchronous reset in WAIT abandons the service
    env_lat = 10;
    @(posedge clk); #1;
    req_ready[3] = 1'b1; req_a[3] = 32'h5555_0005; req_b[3] = 16'd2;
    @(posedge clk); #1 req_ready = '0;
    wait_ready("rst_issue");
    @(posedge clk); #3 reset = 1'b0;
    #1 chk_zero_outputs("midrst");
    @(posedge clk); #1 reset = 1'b1;
    grant_log.delete(); issue_a_log.delete(); env_lat = 3;
    @(posedge clk); #1;
    req_ready[3] = 1'b1; req_a[3] = 32'h6666_0006; req_b[3] = 16'd1;
    @(posedge clk); #1 req_ready = '0;
    wait_idle("post_rst_idle", 30);
    chk("post_rst_len", grant_log.size(), 1);
    if (issue_a_log.size() == 1) chk("post_rst_a", issue_a_log[0], 32'h6666_0006);

`ifdef LSHL_ARB_TIMEOUT_EN
    // watchdog: L_shl never answers
    env_lat = 0;
    @(posedge clk); #1;
    req_ready[1] = 1'b1; req_a[1] = 32'h7777_0007; req_b[1] = 16'd5;
    @(posedge clk); #1 req_ready = '0;
    wait_ready("tmo_issue");
    nd = 0;
    repeat (TMO) begin @(negedge clk); if (req_done != '0) nd++; end
    chk("tmo_early_done", nd, 0);
    @(negedge clk);
    chk("tmo_done", {28'h0, req_done}, 32'h2);
    chk("tmo_result", req_result, 32'h0);
    chk("tmo_flag", {31'h0, shl_timeout}, 32'h1);
    @(negedge clk);
    chk("tmo_flag_drop", {31'h0, shl_timeout}, 32'h0);
    chk("tmo_busy_drop", {31'h0, busy}, 32'h0);
    @(posedge clk); #1; inject_done = 1'b1; inject_in = 32'hDEAD_BEEF;
    @(negedge clk); chk("tmo_late_done", {28'h0, req_done}, 32'h0);
    @(posedge clk); #1 inject_done = 1'b0;
`else
    // without the watchdog a slow L_shl is simply waited for
    env_lat = 100;
    @(posedge clk); #1;
    req_ready[1] = 1'b1; req_a[1] = 32'h7777_0007; req_b[1] = 16'd5;
    @(posedge clk); #1 req_ready = '0;
    wait_ready("long_issue");
    n = 0;
    do begin @(negedge clk); n++; end while (req_done == '0 && n < 200);
    chk("long_latency", n, 100);
    chk("long_timeout_flag", {31'h0, shl_timeout}, 32'h0);
`endif
    wait_idle("pre_rand_idle", 30);

    // randomized traffic
    env_rand = 1;
    repeat (2000) begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        req_ready[i] = ($urandom_range(0, 3) == 0);
        req_a[i]     = $urandom;
        req_b[i]     = 16'($urandom_range(0, 40));
      end
    end
    @(posedge clk); #1 req_ready = '0;
    wait_idle("rand_drain", 500);
    chk("fairness_max_wait", 32'(max_wait <= NREQ - 1), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
